// File: rtl/and20_result_buffer.sv
// and20_result_buffer: registered 2-entry result FIFO behind the 20-bit AND array.
// Each accepted word is stored with precomputed zero / all-ones / popcount flags.
// This lets the downstream stage stall without losing results. The output side
// has no combinational path from in_data.
module and20_result_buffer #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PCW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [PCW-1:0]   out_popcnt,
  input  logic             out_ready,
  output logic [15:0]      accept_cnt
);

  // Pointers and count are sized for exactly two entries.
  if (DEPTH != 2) begin : g_bad_depth
    $error("and20_result_buffer supports DEPTH == 2 only");
  end

  logic [WIDTH-1:0] data_q [2];
  logic             zero_q [2];
  logic             ones_q [2];
  logic [PCW-1:0]   pc_q   [2];

  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic [15:0] accept_cnt_q;

  logic           push, pop;
  logic           zero_d, ones_d;
  logic [PCW-1:0] pc_d;

  // Handshake decode; in_ready/out_valid come only from registered count (and reset).
  always_comb begin
    in_ready  = !reset && (count_q != 2'd2);
    out_valid = !reset && (count_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Flags for the incoming word, computed once at push time.
  always_comb begin
    zero_d = (in_data == '0);
    ones_d = (in_data == '1);
    pc_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pc_d = pc_d + PCW'(in_data[i]);
    end
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy and accepted-beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      accept_cnt_q <= 16'd0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q     <= ~wr_ptr_q;
        accept_cnt_q <= accept_cnt_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Entry storage; contents need no reset since outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= in_data;
      zero_q[wr_ptr_q] <= zero_d;
      ones_q[wr_ptr_q] <= ones_d;
      pc_q[wr_ptr_q]   <= pc_d;
    end
  end

  // Head-entry outputs, forced to zero when nothing valid is held.
  always_comb begin
    out_data   = out_valid ? data_q[rd_ptr_q] : '0;
    out_zero   = out_valid ? zero_q[rd_ptr_q] : 1'b0;
    out_ones   = out_valid ? ones_q[rd_ptr_q] : 1'b0;
    out_popcnt = out_valid ? pc_q[rd_ptr_q]   : '0;
    accept_cnt = accept_cnt_q;
  end

endmodule
